micro_sequencer: RTL

- Microprogram control unit driving the datapath control interface (alu_opcode, shifter_opcode, c_select, b_select) and consuming its n/z flags.
- This is the initiator end of the interface that a testbench drives by hand today.
- Holds a loadable control store, an MPC and an MIR, and issues one microinstruction per clock.
- Branch control is Mic-1 style: JAMN, JAMZ and JMPC.

---
 rtl/micro_sequencer_pkg.sv | 40 ++++
 rtl/micro_sequencer_control_store.sv | 27 ++
 rtl/micro_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_pkg.sv
// micro_seq_pkg: shared definitions for the micro_sequencer slice.
//   - sequencer state encoding
//   - MIR field bit positions
//   - halt address and the halt-word test
//   - ALU opcodes the datapath decodes
package micro_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    // MIR layout
    localparam int MIR_BITS  = 36;
    localparam int NEXT_LSB  = 27;  // [35:27] next_addr
    localparam int JMPC_BIT  = 26;
    localparam int JAMN_BIT  = 25;
    localparam int JAMZ_BIT  = 24;
    localparam int SHIFT_LSB = 22;  // [23:22]
    localparam int ALU_LSB   = 16;  // [21:16]
    localparam int C_LSB     = 7;   // [15:7]
    localparam int WR_BIT    = 6;
    localparam int RD_BIT    = 5;
    localparam int FETCH_BIT = 4;
    localparam int B_LSB     = 0;   // [3:0]

    localparam logic [8:0] HALT_ADDR = 9'h1FF;

    // ALU opcodes recognised by the datapath
    localparam logic [5:0] ALU_OP_A = 6'b110001;
    localparam logic [5:0] ALU_OP_B = 6'b111001;

    // A halt word jumps unconditionally to HALT_ADDR; any JAM bit makes it a
    // plain jump instead.
    function automatic logic is_halt_word(input logic [MIR_BITS-1:0] w);
        return (w[NEXT_LSB +: 9] == HALT_ADDR) && (w[JAMZ_BIT +: 3] == 3'b000);
    endfunction

endpackage

// File: rtl/micro_sequencer_control_store.sv
// control_store: DEPTH x DW microcode array.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  synchronous write port
//   raddr_i/rdata_o       asynchronous read port
// Contents are not reset.
module control_store #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 36
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: Mic-1 style microprogram control unit.
//   clock, reset (async, active-low)
//   start            begin execution (ignored in RUN)
//   busy / halted    state indicators
//   cs_we/cs_waddr/cs_wdata  control-store load port (ignored in RUN)
//   n, z, mbr        datapath flags and opcode byte for JAMN/JAMZ/JMPC
//   alu_opcode, shifter_opcode, c_select, b_select, mem_rd, mem_wr,
//   mem_fetch        control word, driven straight from the MIR register
//   mpc              address of the word currently in the MIR
// Optional macro MICRO_SEQUENCER_BREAKPOINT_EN adds bp_en/bp_addr: a RUN
// edge whose next address equals bp_addr halts instead, and the following
// start resumes at that address.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int         CS_DEPTH   = 512,
    parameter int         ADDR_W     = 9,
    parameter int         MIR_W      = 36,
    parameter logic [8:0] START_ADDR = 9'h000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    input  logic              cs_we,
    input  logic [ADDR_W-1:0] cs_waddr,
    input  logic [MIR_W-1:0]  cs_wdata,
    input  logic              n,
    input  logic              z,
    input  logic [7:0]        mbr,
`ifdef MICRO_SEQUENCER_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
`endif
    output logic [5:0]        alu_opcode,
    output logic [1:0]        shifter_opcode,
    output logic [8:0]        c_select,
    output logic [3:0]        b_select,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_fetch,
    output logic [ADDR_W-1:0] mpc
);

    seq_state_e        state_q;
    logic [MIR_W-1:0]  mir_q;
    logic [ADDR_W-1:0] mpc_q;
    logic [ADDR_W-1:0] nxt_d;
    logic [ADDR_W-1:0] entry_d;
    logic [ADDR_W-1:0] raddr_d;
    logic [MIR_W-1:0]  cs_rdata;
    logic              halt_word;

`ifdef MICRO_SEQUENCER_BREAKPOINT_EN
    logic              resume_q;  // last halt came from a breakpoint
`endif

    // Live flags feed the branch directly, so a JAM sees the flags produced
    // by the same microinstruction it sits in.
    always_comb begin
        nxt_d = {mir_q[NEXT_LSB+8] | (mir_q[JAMN_BIT] & n) | (mir_q[JAMZ_BIT] & z),
                 mir_q[NEXT_LSB +: 8] | (mir_q[JMPC_BIT] ? mbr : 8'h00)};
        halt_word = is_halt_word(mir_q);
        entry_d   = START_ADDR;
`ifdef MICRO_SEQUENCER_BREAKPOINT_EN
        if (resume_q) entry_d = mpc_q;
`endif
        raddr_d = (state_q == RUN) ? nxt_d : entry_d;
    end

    // Read is combinational, so a write landing on the start edge is not
    // seen by that fetch.
    control_store #(
        .DEPTH (CS_DEPTH),
        .AW    (ADDR_W),
        .DW    (MIR_W)
    ) u_cs (
        .clk_i   (clock),
        .we_i    (cs_we && (state_q != RUN)),
        .waddr_i (cs_waddr),
        .wdata_i (cs_wdata),
        .raddr_i (raddr_d),
        .rdata_o (cs_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mir_q    <= '0;
            mpc_q    <= '0;
`ifdef MICRO_SEQUENCER_BREAKPOINT_EN
            resume_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        mir_q    <= cs_rdata;
                        mpc_q    <= entry_d;
                        state_q  <= RUN;
`ifdef MICRO_SEQUENCER_BREAKPOINT_EN
                        resume_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (halt_word) begin
                        // halt word has had its cycle; replace it with a NOP
                        mir_q   <= '0;
                        state_q <= HALT;
                    end
`ifdef MICRO_SEQUENCER_BREAKPOINT_EN
                    else if (bp_en && (nxt_d == bp_addr)) begin
                        mir_q    <= '0;
                        mpc_q    <= bp_addr;
                        state_q  <= HALT;
                        resume_q <= 1'b1;
                    end
`endif
                    else begin
                        mir_q <= cs_rdata;
                        mpc_q <= nxt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mir_q   <= '0;
                end
            endcase
        end
    end

    assign busy           = (state_q == RUN);
    assign halted         = (state_q == HALT);
    assign alu_opcode     = mir_q[ALU_LSB +: 6];
    assign shifter_opcode = mir_q[SHIFT_LSB +: 2];
    assign c_select       = mir_q[C_LSB +: 9];
    assign b_select       = mir_q[B_LSB +: 4];
    assign mem_rd         = mir_q[RD_BIT];
    assign mem_wr         = mir_q[WR_BIT];
    assign mem_fetch      = mir_q[FETCH_BIT];
    assign mpc            = mpc_q;

endmodule
